// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock controller: state encoding,
// default timing constants and a counter-width helper.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_t;

  localparam int DEF_RST_PULSE_CYC    = 16;
  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYC = 65536;
  localparam int DEF_MAX_RETRY        = 3;

  // Bits needed for a counter that must represent 0..max(a,b,c).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic meta_reg;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= 1'b0;
      q        <= 1'b0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL bring-up controller: pulses the PLL reset, waits for a synchronized
// lock, demands a stable lock window, then releases the downstream reset.
// Timeouts retry the bring-up up to MAX_RETRY times before latching a fault.
//
// Timing with pll_lock steady high from reset release: pll_reset stays high
// for RST_PULSE_CYC edges, WAIT_LOCK sees lock_s on the next edge, and STABLE
// occupies LOCK_STABLE_CYC+1 edges (the counter holds the number of lock_s
// cycles already accumulated; RUN is taken on the sample that confirms a full
// window). ready therefore rises RST_PULSE_CYC + LOCK_STABLE_CYC + 2 edges
// after release (14 edges for 4/8). All outputs are registered copies of a
// decode of the next state.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRY);

  pll_state_t       state_reg;
  pll_state_t       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       retry_next;
  logic             lock_s;

  sync_2ff u_lock_sync (
    .clk  (clkin),
    .srst (reset),
    .d    (pll_lock),
    .q    (lock_s)
  );

  // Next-state and retry bookkeeping; relock_req only matters in RUN and FAULT.
  always_comb begin
    state_next = state_reg;
    retry_next = retry_cnt;
    case (state_reg)
      ST_RST_PLL: begin
        if (cnt_reg == RST_LAST) state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = ST_STABLE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          if (retry_cnt < RETRY_LIMIT) begin
            retry_next = retry_cnt + 2'd1;
            state_next = ST_RST_PLL;
          end else begin
            state_next = ST_FAULT;
          end
        end
      end
      ST_STABLE: begin
        if (!lock_s)                     state_next = ST_WAIT_LOCK;
        else if (cnt_reg == STABLE_LAST) state_next = ST_RUN;
      end
      ST_RUN: begin
        // Lock loss and relock request collapse into a single restart.
        if (!lock_s || relock_req) state_next = ST_RST_PLL;
      end
      ST_FAULT: begin
        if (relock_req) begin
          state_next = ST_RST_PLL;
          retry_next = 2'd0;
        end
      end
      default: state_next = ST_RST_PLL;
    endcase
    if (state_next == ST_RUN) retry_next = 2'd0;
  end

  // State, saturating shared counter and next-state-decoded output registers.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_reg <= ST_RST_PLL;
      cnt_reg   <= '0;
      pll_reset <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 2'd0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg) cnt_reg <= '0;
      else if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
      pll_reset <= (state_next == ST_RST_PLL) || (state_next == ST_FAULT);
      sys_reset <= (state_next != ST_RUN);
      ready     <= (state_next == ST_RUN);
      fault     <= (state_next == ST_FAULT);
      retry_cnt <= retry_next;
    end
  end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench for pll_lock_ctrl. Each segment starts with two reset
// cycles, then plays pre-generated pll_lock/relock_req waveforms. A span-based
// reference model turns each waveform into the list of output transitions
// (edge, value) that are queued; a monitor pops one entry per observed change.
module tb_pll_lock_ctrl;

  localparam int P    = 4;
  localparam int S    = 8;
  localparam int T    = 32;
  localparam int M    = 2;
  localparam int MAXN = 256;
  localparam logic [5:0] RST_V = 6'b110000;

  typedef struct {
    int         at;
    logic [5:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_reset, sys_reset, ready, fault;
  logic [1:0] retry_cnt;
  logic [5:0] dout;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [5:0] mon_prev;
  logic [5:0] last_exp;
  ev_t        exp_q[$];

  bit         lk[MAXN];
  bit         rq[MAXN];
  logic [5:0] eo[MAXN];
  int         seg_n;

  pll_lock_ctrl #(
    .RST_PULSE_CYC    (P),
    .LOCK_STABLE_CYC  (S),
    .LOCK_TIMEOUT_CYC (T),
    .MAX_RETRY        (M)
  ) dut (
    .clkin      (clk),
    .reset      (rst),
    .pll_lock   (pll_lock),
    .relock_req (relock_req),
    .pll_reset  (pll_reset),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt)
  );

  assign dout = {pll_reset, sys_reset, ready, fault, retry_cnt};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] ov(input bit pr, input bit sr, input bit rd,
                                    input bit ft, input int rc);
    logic [1:0] r2;
    r2 = rc[1:0];
    return {pr, sr, rd, ft, r2};
  endfunction

  // lock_s as seen by the controller at local edge k: two-edge latency, and
  // the synchronizer is cleared while reset is held (local edges 0 and 1).
  function automatic bit locks(input int k);
    return (k >= 4) && lk[k-2];
  endfunction

  // Expected outputs per local edge, built phase by phase from the waveform.
  task automatic run_model();
    int e, k, retry, ph;
    for (int i = 0; i < seg_n; i++) eo[i] = RST_V;
    e = 1; retry = 0; ph = 0;
    while (e < seg_n) begin
      case (ph)
        0: begin  // PLL held in reset for P edges
          for (int i = e; i < e + P && i < seg_n; i++) eo[i] = ov(1, 1, 0, 0, retry);
          e = e + P; ph = 1;
        end
        1: begin  // waiting for first lock, timeout after T edges
          eo[e] = ov(0, 1, 0, 0, retry);
          k = e + 1;
          while (k < seg_n && k < e + T && !locks(k)) begin
            eo[k] = ov(0, 1, 0, 0, retry); k++;
          end
          if (k >= seg_n) e = seg_n;
          else if (locks(k)) begin e = k; ph = 2; end
          else begin
            e = k;
            if (retry < M) begin retry++; ph = 0; end
            else ph = 4;
          end
        end
        2: begin  // stability window
          eo[e] = ov(0, 1, 0, 0, retry);
          k = e + 1;
          while (k < seg_n && k < e + S + 1 && locks(k)) begin
            eo[k] = ov(0, 1, 0, 0, retry); k++;
          end
          if (k >= seg_n) e = seg_n;
          else if (!locks(k)) begin e = k; ph = 1; end
          else begin e = k; retry = 0; ph = 3; end
        end
        3: begin  // running until lock loss or relock request
          eo[e] = ov(0, 0, 1, 0, 0);
          k = e + 1;
          while (k < seg_n && locks(k) && !rq[k]) begin
            eo[k] = ov(0, 0, 1, 0, 0); k++;
          end
          if (k >= seg_n) e = seg_n;
          else begin e = k; ph = 0; end
        end
        default: begin  // fault until relock request
          eo[e] = ov(1, 1, 0, 1, retry);
          k = e + 1;
          while (k < seg_n && !rq[k]) begin
            eo[k] = ov(1, 1, 0, 1, retry); k++;
          end
          if (k >= seg_n) e = seg_n;
          else begin e = k; retry = 0; ph = 0; end
        end
      endcase
    end
  endtask

  task automatic set_all(input int n, input bit v);
    seg_n = n;
    for (int i = 0; i < MAXN; i++) begin lk[i] = v; rq[i] = 1'b0; end
  endtask

  task automatic gen_random();
    int i, len;
    bit v;
    set_all(160, 1'b1);
    v = 1'b1; i = 0;
    while (i < seg_n) begin
      if (v) len = $urandom_range(3, 40);
      else if ($urandom_range(0, 3) == 0) len = $urandom_range(20, 60);
      else len = $urandom_range(1, 4);
      for (int j = 0; j < len && i < seg_n; j++) begin
        lk[i] = v;
        rq[i] = (i >= 2) && ($urandom_range(0, 39) == 0);
        i++;
      end
      v = !v;
    end
  endtask

  // Model the prepared segment, queue its transitions, then play it.
  task automatic play_seg();
    int c0;
    ev_t ev;
    @(negedge clk);
    c0 = cyc;
    run_model();
    for (int i = 0; i < seg_n; i++) begin
      if (eo[i] !== last_exp) begin
        ev.at = c0 + 1 + i; ev.val = eo[i];
        exp_q.push_back(ev);
        last_exp = eo[i];
      end
    end
    for (int i = 0; i < seg_n; i++) begin
      rst        = (i < 2);
      pll_lock   = lk[i];
      relock_req = rq[i];
      if (i < seg_n - 1) @(negedge clk);
    end
  endtask

  // Monitor: one scoreboard comparison per observed output change.
  initial begin : monitor
    ev_t ev;
    forever begin
      @(negedge clk);
      if (mon_en && (dout !== mon_prev)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%b required=%b (no change)", cyc, dout, mon_prev);
        end else begin
          ev = exp_q.pop_front();
          if ((ev.at != cyc) || (ev.val !== dout)) begin
            errors++;
            $display("FAIL transition got=%b at cyc %0d required=%b at cyc %0d", dout, cyc, ev.val, ev.at);
          end else begin
            $display("cyc=%0d pll_reset=%b sys_reset=%b ready=%b fault=%b retry_cnt=%0d ok",
                     cyc, pll_reset, sys_reset, ready, fault, retry_cnt);
          end
        end
        mon_prev = dout;
      end
    end
  end

  initial begin : stimulus
    int d, len, c0;
    ev_t ev;
    rst = 1'b1; pll_lock = 1'b0; relock_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dout !== RST_V) begin
      errors++;
      $display("FAIL reset_state got=%b required=%b", dout, RST_V);
    end
    mon_prev = RST_V; last_exp = RST_V; mon_en = 1'b1;

    // Lock tied high: plain bring-up.
    set_all(40, 1'b1); play_seg();
    // Lock never arrives: retries, fault, then relock request with lock present.
    set_all(150, 1'b0);
    d = 115 + $urandom_range(0, 5);
    rq[d] = 1'b1;
    for (int i = d; i < seg_n; i++) lk[i] = 1'b1;
    play_seg();
    // Single-cycle glitch inside the stability window.
    repeat (3) begin
      set_all(50, 1'b1); lk[$urandom_range(5, 13)] = 1'b0; play_seg();
    end
    // Lock drop while running.
    repeat (3) begin
      set_all(80, 1'b1);
      d = $urandom_range(16, 30); len = $urandom_range(1, 5);
      for (int i = d; i < d + len; i++) lk[i] = 1'b0;
      play_seg();
    end
    // Lock drop and relock request reaching the controller on the same edge.
    repeat (2) begin
      set_all(80, 1'b1);
      d = $urandom_range(16, 30); lk[d] = 1'b0; rq[d+2] = 1'b1;
      play_seg();
    end
    // Relock request alone while running.
    repeat (2) begin
      set_all(80, 1'b1); rq[$urandom_range(16, 30)] = 1'b1; play_seg();
    end
    // Stop inside STABLE so the next segment's reset lands there.
    set_all(10, 1'b1); play_seg();
    set_all(40, 1'b1); play_seg();
    // Stop inside FAULT so the next segment's reset lands there.
    set_all(115, 1'b0); play_seg();
    repeat (6) begin
      gen_random(); play_seg();
    end

    // Tail: hold reset so nothing further changes, then drain the scoreboard.
    @(negedge clk);
    c0 = cyc;
    if (last_exp !== RST_V) begin
      ev.at = c0 + 1; ev.val = RST_V; exp_q.push_back(ev); last_exp = RST_V;
    end
    rst = 1'b1; pll_lock = 1'b0; relock_req = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_transitions got=%0d pending required=0 pending", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 SHALL have parameter RST_PULSE_CYC, default 16: number of cycles pll_reset is held high per PLL reset attempt.
REQ-002 SHALL have parameter LOCK_STABLE_CYC, default 1024: number of consecutive synchronized-lock cycles required before release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYC, default 65536: maximum number of cycles to wait for first lock after pll_reset deasserts.
REQ-004 SHALL have parameter MAX_RETRY, default 3: number of timeout retries before fault; range 1..3.
REQ-005 SHALL have port clkin, input, 1 bit: single free-running reference clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pll_lock, input, 1 bit: PLL lock flag, asynchronous to clkin.
REQ-008 SHALL have port relock_req, input, 1 bit: single-cycle request to restart the PLL.
REQ-009 SHALL have port pll_reset, output, 1 bit: drives the PLL RESET pin.
REQ-010 SHALL have port sys_reset, output, 1 bit: active-high reset for downstream logic.
REQ-011 SHALL have port ready, output, 1 bit: PLL locked and stable.
REQ-012 SHALL have port fault, output, 1 bit: retries exhausted.
REQ-013 SHALL have port retry_cnt, output, 2 bits: number of timeouts in the current bring-up.

Function
REQ-014 SHALL pass pll_lock through a 2-flop synchronizer (lock_s); lock_s lags pll_lock by 2 cycles.
REQ-015 SHALL implement an FSM with states RST_PLL, WAIT_LOCK, STABLE, RUN and FAULT, plus one shared cycle counter.
REQ-016 RST_PLL: pll_reset=1 and sys_reset=1; after RST_PULSE_CYC cycles, SHALL go to WAIT_LOCK and clear the counter.
REQ-017 WAIT_LOCK: pll_reset=0; if lock_s=1, SHALL go to STABLE and clear the counter.
REQ-018 WAIT_LOCK timeout: if the counter reaches LOCK_TIMEOUT_CYC-1 with lock_s=0 and retry_cnt<MAX_RETRY, SHALL increment retry_cnt and go to RST_PLL; otherwise SHALL go to FAULT.
REQ-019 STABLE: if lock_s=0 on any cycle, SHALL return to WAIT_LOCK with the counter cleared; after LOCK_STABLE_CYC consecutive lock_s=1 cycles, SHALL go to RUN.
REQ-020 On RUN entry, SHALL set sys_reset=0 and ready=1, and clear retry_cnt.
REQ-021 RUN: lock_s=0 or relock_req=1 SHALL cause a transition to RUN->RST_PLL; sys_reset=1 and ready=0 on the next edge. Both events in the same cycle SHALL produce exactly one transition.
REQ-022 FAULT: pll_reset=1, sys_reset=1, fault=1; only relock_req SHALL exit, to RST_PLL, clearing fault and retry_cnt.
REQ-023 relock_req in RST_PLL, WAIT_LOCK or STABLE SHALL be ignored.
REQ-024 All outputs SHALL be registered and decoded from the next state, so each changes on the same edge as the state register.
REQ-025 The counter SHALL be wide enough for the largest parameter, SHALL saturate and never wrap, and SHALL be cleared on every state change.
REQ-026 sys_reset SHALL be 0 only in RUN; ready SHALL equal (state==RUN).

Reset
REQ-027 reset=1 SHALL set state=RST_PLL, counter=0, sync flops=0, pll_reset=1, sys_reset=1, ready=0, fault=0, retry_cnt=0.
REQ-028 reset asserted mid-operation, in any state, SHALL force the REQ-027 values on the next edge; the pll_reset pulse SHALL then restart at full length.

Structure
REQ-029 Shared package pll_ctrl_pkg SHALL hold the state encoding and the default parameter constants.
REQ-030 The 2-flop synchronizer SHALL be the sub-module sync_2ff; all other logic SHALL be in pll_lock_ctrl.

Verification (RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, MAX_RETRY=2)
REQ-031 Release reset with pll_lock tied 1 -> pll_reset high exactly 4 cycles; ready=1 and sys_reset=0 at cycle 4+2+1+8 (±1, documented exact value).
REQ-032 pll_lock held 0 -> pll_reset pulses 3 times, retry_cnt goes 1 then 2; fault=1 after the 3rd timeout; relock_req then clears fault and restarts the pulse.
REQ-033 Glitch pll_lock low for 1 cycle during STABLE -> returns to WAIT_LOCK; ready is delayed by a full 8-cycle window after lock_s recovers.
REQ-034 In RUN, drop pll_lock -> sys_reset=1 and ready=0 exactly 3 cycles after the drop; the new pll_reset pulse is 4 cycles.
REQ-035 In RUN, assert relock_req and drop lock_s in the same cycle -> exactly one RST_PLL entry and one 4-cycle pulse.
REQ-036 Assert reset during STABLE and during FAULT -> all outputs reach REQ-027 values on the next edge.
